uart_frame_sender: RTL and testbench

UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

---
 rtl/uart_frame_sender.sv | 163 ++++++++++++++++
 tb/tb_uart_frame_sender.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sender.sv
// Byte-queued UART transmitter: FIFO in front of an 8E1/8E2 frame serializer.
module uart_frame_sender #(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                          clock,
   input  logic                          init_flag,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   input  logic                          clr_ovf,
   output logic                          tx,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          busy,
   output logic                          overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = $clog2(CLK_DIV);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            parity_q, parity_d;
   logic            tx_d;
   logic            pop_c, bit_done_c, wr_acc_c, wr_drop_c;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]   count_d;

   // Full is judged before any same-edge pop, so a write into a full FIFO is always dropped.
   assign bit_done_c = (bit_cnt_q == BW'(CLK_DIV - 1));
   assign wr_acc_c   = wr_en && !full;
   assign wr_drop_c  = wr_en && full;
   assign count_d    = count + CW'(wr_acc_c) - CW'(pop_c);

   // Next-state, serializer datapath and FIFO pop decision.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_done_c ? '0 : bit_cnt_q + BW'(1);
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      parity_d  = parity_q;
      tx_d      = tx;
      pop_c     = 1'b0;
      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            if (!empty) begin
               pop_c    = 1'b1;
               state_d  = START;
               shreg_d  = mem[rd_ptr_q];
               parity_d = ^mem[rd_ptr_q];
               tx_d     = 1'b0;
            end
         end
         START: begin
            if (bit_done_c) begin
               state_d   = DATA;
               bit_idx_d = 3'd0;
               tx_d      = shreg_q[0];
               shreg_d   = {1'b0, shreg_q[7:1]};
            end
         end
         DATA: begin
            if (bit_done_c) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = PARITY;
                  tx_d    = parity_q;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shreg_q[0];
                  shreg_d   = {1'b0, shreg_q[7:1]};
               end
            end
         end
         PARITY: begin
            if (bit_done_c) begin
               state_d   = STOP;
               bit_idx_d = 3'd0;
               tx_d      = 1'b1;
            end
         end
         STOP: begin
            if (bit_done_c) begin
               if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                  if (!empty) begin
                     pop_c    = 1'b1;
                     state_d  = START;
                     shreg_d  = mem[rd_ptr_q];
                     parity_d = ^mem[rd_ptr_q];
                     tx_d     = 1'b0;
                  end else begin
                     state_d = IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tx_d      = 1'b1;
         end
      endcase
   end

   // FSM and serializer registers; reset aborts any frame with the line idle-high.
   always_ff @(posedge clock or negedge init_flag) begin
      if (!init_flag) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         bit_idx_q <= 3'd0;
         shreg_q   <= 8'd0;
         parity_q  <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         parity_q  <= parity_d;
         tx        <= tx_d;
         busy      <= (state_d != IDLE);
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clock) begin
      if (wr_acc_c) mem[wr_ptr_q] <= wr_data;
   end

   // FIFO pointers, occupancy flags and sticky overflow (set beats clear).
   always_ff @(posedge clock or negedge init_flag) begin
      if (!init_flag) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_acc_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_c)    rd_ptr_q <= rd_ptr_q + AW'(1);
         count <= count_d;
         full  <= (count_d == CW'(FIFO_DEPTH));
         empty <= (count_d == '0);
         if (wr_drop_c)    overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_frame_sender.sv
// Directed bench for uart_frame_sender: frame timing, back-to-back frames, overflow, reset abort, two stop bits.
module tb_uart_frame_sender;

   logic       clock;
   logic       init_flag;
   logic       wr_en, wr_en2;
   logic [7:0] wr_data, wr_data2;
   logic       clr_ovf;
   logic       tx, full, empty, busy, overflow;
   logic [3:0] count;
   logic       tx2, full2, empty2, busy2, overflow2;
   logic [3:0] count2;

   int n_checks = 0;
   int n_pass   = 0;

   uart_frame_sender #(.CLK_DIV(4), .FIFO_DEPTH(8), .STOP_BITS(1)) dut (
      .clock(clock), .init_flag(init_flag), .wr_en(wr_en), .wr_data(wr_data),
      .clr_ovf(clr_ovf), .tx(tx), .full(full), .empty(empty), .count(count),
      .busy(busy), .overflow(overflow)
   );

   uart_frame_sender #(.CLK_DIV(4), .FIFO_DEPTH(8), .STOP_BITS(2)) dut2 (
      .clock(clock), .init_flag(init_flag), .wr_en(wr_en2), .wr_data(wr_data2),
      .clr_ovf(clr_ovf), .tx(tx2), .full(full2), .empty(empty2), .count(count2),
      .busy(busy2), .overflow(overflow2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Walk a frame bit by bit (bit 0 = start), 4 clocks per bit, busy high throughout.
   task automatic check_frame(input string tag, input logic [11:0] f, input int nbits, input int which);
      for (int k = 0; k < nbits; k++) begin
         for (int c = 0; c < 4; c++) begin
            if (which == 0) begin
               chk($sformatf("%s_tx_b%0d_c%0d", tag, k, c), 32'(tx), 32'(f[k]));
               chk($sformatf("%s_busy_b%0d_c%0d", tag, k, c), 32'(busy), 32'd1);
            end else begin
               chk($sformatf("%s_tx2_b%0d_c%0d", tag, k, c), 32'(tx2), 32'(f[k]));
               chk($sformatf("%s_busy2_b%0d_c%0d", tag, k, c), 32'(busy2), 32'd1);
            end
            tick();
         end
      end
   endtask

   initial begin
      init_flag = 1'b0;
      wr_en = 1'b0; wr_data = 8'h00;
      wr_en2 = 1'b0; wr_data2 = 8'h00;
      clr_ovf = 1'b0;
      #12;
      // Reset state
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_tx2", 32'(tx2), 32'd1);
      chk("rst_busy2", 32'(busy2), 32'd0);
      chk("rst_empty2", 32'(empty2), 32'd1);
      chk("rst_full2", 32'(full2), 32'd0);
      chk("rst_count2", 32'(count2), 32'd0);
      chk("rst_ovf2", 32'(overflow2), 32'd0);
      @(negedge clock) init_flag = 1'b1;
      tick(); tick();

      // Single byte 0xA5: parity 0, tx falls one edge after the write edge
      wr_en = 1'b1; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      chk("a5_pre_tx", 32'(tx), 32'd1);
      chk("a5_pre_busy", 32'(busy), 32'd0);
      chk("a5_pre_count", 32'(count), 32'd1);
      chk("a5_pre_empty", 32'(empty), 32'd0);
      tick();
      check_frame("a5", {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 0);
      chk("a5_post_busy", 32'(busy), 32'd0);
      chk("a5_post_tx", 32'(tx), 32'd1);
      chk("a5_post_empty", 32'(empty), 32'd1);

      // 0x01 then 0x80 back-to-back, both parity 1, no gap between frames
      wr_en = 1'b1; wr_data = 8'h01;
      tick();
      wr_data = 8'h80;
      tick();
      wr_en = 1'b0;
      chk("b2b_count", 32'(count), 32'd1);
      check_frame("b2b_01", {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 0);
      check_frame("b2b_80", {1'b0, 1'b1, 1'b1, 8'h80, 1'b0}, 11, 0);
      chk("b2b_post_busy", 32'(busy), 32'd0);
      chk("b2b_post_tx", 32'(tx), 32'd1);

      // Nine writes during a frame: eight fill the FIFO, the ninth is dropped
      wr_en = 1'b1; wr_data = 8'h3C;
      tick();
      wr_en = 1'b0;
      tick();
      chk("ovf_start_tx", 32'(tx), 32'd0);
      chk("ovf_start_count", 32'(count), 32'd0);
      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
      end
      wr_en = 1'b0;
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_empty", 32'(empty), 32'd0);
      tick();
      chk("ovf_sticky", 32'(overflow), 32'd1);
      wr_en = 1'b1; clr_ovf = 1'b1;
      tick();
      chk("ovf_set_wins", 32'(overflow), 32'd1);
      chk("ovf_set_wins_count", 32'(count), 32'd8);
      wr_en = 1'b0;
      tick();
      clr_ovf = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      chk("ovf_cleared_count", 32'(count), 32'd8);

      // Write on the very edge the FSM pops from a full FIFO: rejected
      repeat (31) tick();
      chk("popedge_pre_count", 32'(count), 32'd8);
      chk("popedge_pre_tx", 32'(tx), 32'd1);
      chk("popedge_pre_busy", 32'(busy), 32'd1);
      wr_en = 1'b1; wr_data = 8'hEE;
      tick();
      wr_en = 1'b0;
      chk("popedge_ovf", 32'(overflow), 32'd1);
      chk("popedge_count", 32'(count), 32'd7);
      chk("popedge_full", 32'(full), 32'd0);
      chk("popedge_tx", 32'(tx), 32'd0);

      // Asynchronous reset during data bit 3 of byte 0x00
      repeat (17) tick();
      chk("abort_pre_tx", 32'(tx), 32'd0);
      chk("abort_pre_busy", 32'(busy), 32'd1);
      #2 init_flag = 1'b0;
      #1;
      chk("abort_tx", 32'(tx), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_count", 32'(count), 32'd0);
      chk("abort_empty", 32'(empty), 32'd1);
      chk("abort_full", 32'(full), 32'd0);
      chk("abort_ovf", 32'(overflow), 32'd0);
      @(negedge clock) init_flag = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk($sformatf("quiet_tx_%0d", i), 32'(tx), 32'd1);
         chk($sformatf("quiet_busy_%0d", i), 32'(busy), 32'd0);
      end

      // Two stop bits, byte 0xFF: parity 0, 48-cycle frame
      wr_en2 = 1'b1; wr_data2 = 8'hFF;
      tick();
      wr_en2 = 1'b0;
      chk("ff_pre_tx2", 32'(tx2), 32'd1);
      tick();
      check_frame("ff", {2'b11, 1'b0, 8'hFF, 1'b0}, 12, 1);
      chk("ff_post_busy2", 32'(busy2), 32'd0);
      chk("ff_post_tx2", 32'(tx2), 32'd1);
      chk("ff_post_empty2", 32'(empty2), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
